// File: rtl/aexm_memarb_pkg.sv
// Shared types and helpers for the aexm memory arbiter.
// Optional feature macro: AEXM_MEMARB_RR_EN (round-robin tie break).
package aexm_memarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IC   = 2'd1,
    GNT_DC   = 2'd2
  } grant_t;

  // Mask clearing the byte offset inside one burst line (BEATS words of 4 bytes).
  function automatic logic [63:0] line_mask(input int beats);
    return ~((64'd1 << ($clog2(beats) + 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/aexm_memarb_pick.sv
// Combinational winner selection between icache and dcache requests.
// With AEXM_MEMARB_RR_EN a tie goes to the cache not granted last;
// otherwise the dcache always wins a tie.
module aexm_memarb_pick
  import aexm_memarb_pkg::*;
(
  input  logic       ic_req_i,
  input  logic       dc_req_i,
`ifdef AEXM_MEMARB_RR_EN
  input  logic [1:0] last_grant_i,
`endif
  output logic [1:0] grant_o
);

  // Pick the winner from the live requests.
  always_comb begin
    grant_o = GNT_NONE;
    if (ic_req_i && dc_req_i) begin
`ifdef AEXM_MEMARB_RR_EN
      grant_o = (last_grant_i == GNT_DC) ? GNT_IC : GNT_DC;
`else
      grant_o = GNT_DC;
`endif
    end else if (dc_req_i) begin
      grant_o = GNT_DC;
    end else if (ic_req_i) begin
      grant_o = GNT_IC;
    end
  end

endmodule

// File: rtl/aexm_memarb.sv
// aexm memory arbiter: icache/dcache line traffic onto one memory port.
// Each grant is a command phase then a BEATS-word burst, then a done pulse.
// Optional feature macro: AEXM_MEMARB_RR_EN (round-robin instead of dcache priority).
module aexm_memarb
  import aexm_memarb_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int AW    = 32
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          ic_req_i,
  input  logic [AW-1:0] ic_addr_i,
  output logic [31:0]   ic_rdata_o,
  output logic          ic_rvalid_o,
  output logic          ic_done_o,
  input  logic          dc_req_i,
  input  logic          dc_we_i,
  input  logic [AW-1:0] dc_addr_i,
  input  logic [31:0]   dc_wdata_i,
  output logic          dc_wnext_o,
  output logic [31:0]   dc_rdata_o,
  output logic          dc_rvalid_o,
  output logic          dc_done_o,
  output logic          mem_cmd_valid_o,
  input  logic          mem_cmd_ready_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_wready_i,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_rvalid_i
);

  localparam int            BW        = $clog2(BEATS);
  localparam logic [AW-1:0] LINE_MASK = AW'(line_mask(BEATS));
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [1:0]    pick_gnt;
  logic          rd_fire, wr_fire;

`ifdef AEXM_MEMARB_RR_EN
  grant_t        last_grant_q, last_grant_d;
`endif

  aexm_memarb_pick u_pick (
    .ic_req_i     (ic_req_i),
    .dc_req_i     (dc_req_i),
`ifdef AEXM_MEMARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_o      (pick_gnt)
  );

  // Beat handshakes only count in DATA and only in the latched direction;
  // stray beats in other states or the wrong direction are dropped.
  always_comb begin
    rd_fire = (state_q == DATA) && !we_q && mem_rvalid_i;
    wr_fire = (state_q == DATA) &&  we_q && mem_wready_i;
  end

  // Next-state logic: grant in IDLE, command handshake, beat counting, done.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
`ifdef AEXM_MEMARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_t'(pick_gnt) != GNT_NONE) begin
          grant_d = grant_t'(pick_gnt);
          state_d = CMD;
          if (grant_t'(pick_gnt) == GNT_DC) begin
            addr_d = dc_addr_i & LINE_MASK;
            we_d   = dc_we_i;
          end else begin
            addr_d = ic_addr_i & LINE_MASK;
            we_d   = 1'b0;
          end
        end
      end
      CMD: begin
        if (mem_cmd_ready_i) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (rd_fire || wr_fire) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      DONE: begin
`ifdef AEXM_MEMARB_RR_EN
        last_grant_d = grant_q;
`endif
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any burst.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef AEXM_MEMARB_RR_EN
      last_grant_q <= GNT_IC;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
`ifdef AEXM_MEMARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Outputs: data paths are forwarded combinationally and zeroed when idle.
  always_comb begin
    mem_cmd_valid_o = (state_q == CMD);
    mem_addr_o      = addr_q;
    mem_we_o        = we_q;
    mem_wdata_o     = ((state_q == DATA) && we_q) ? dc_wdata_i : 32'd0;
    ic_rvalid_o     = rd_fire && (grant_q == GNT_IC);
    dc_rvalid_o     = rd_fire && (grant_q == GNT_DC);
    ic_rdata_o      = ic_rvalid_o ? mem_rdata_i : 32'd0;
    dc_rdata_o      = dc_rvalid_o ? mem_rdata_i : 32'd0;
    dc_wnext_o      = wr_fire && (grant_q == GNT_DC);
    ic_done_o       = (state_q == DONE) && (grant_q == GNT_IC);
    dc_done_o       = (state_q == DONE) && (grant_q == GNT_DC);
  end

endmodule

// File: tb/tb_aexm_memarb.sv
// Self-checking bench for aexm_memarb: directed steps plus randomized grants
// against a request-level reference model (winner choice, aligned address,
// expected beats and done pulse).
module tb_aexm_memarb;

  localparam int          BEATS = 4;
  localparam int          AW    = 32;
  localparam logic [31:0] LINE  = BEATS * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [31:0]   dc_wdata = '0;
  logic          mem_cmd_ready = 1'b0;
  logic          mem_wready = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  logic [31:0]   ic_rdata_o, dc_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          ic_rvalid_o, ic_done_o, dc_wnext_o, dc_rvalid_o, dc_done_o;
  logic          mem_cmd_valid_o, mem_we_o;

  int checks = 0;
  int errors = 0;
  bit          pat[$];
  logic [31:0] dq[$];
`ifdef AEXM_MEMARB_RR_EN
  int last_ref = 1;
`endif

  always #5 clk = ~clk;

  aexm_memarb #(.BEATS(BEATS), .AW(AW)) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (rst_n),
    .ic_req_i        (ic_req),
    .ic_addr_i       (ic_addr),
    .ic_rdata_o      (ic_rdata_o),
    .ic_rvalid_o     (ic_rvalid_o),
    .ic_done_o       (ic_done_o),
    .dc_req_i        (dc_req),
    .dc_we_i         (dc_we),
    .dc_addr_i       (dc_addr),
    .dc_wdata_i      (dc_wdata),
    .dc_wnext_o      (dc_wnext_o),
    .dc_rdata_o      (dc_rdata_o),
    .dc_rvalid_o     (dc_rvalid_o),
    .dc_done_o       (dc_done_o),
    .mem_cmd_valid_o (mem_cmd_valid_o),
    .mem_cmd_ready_i (mem_cmd_ready),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wready_i    (mem_wready),
    .mem_rdata_i     (mem_rdata),
    .mem_rvalid_i    (mem_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_last(input int g);
`ifdef AEXM_MEMARB_RR_EN
    last_ref = g;
`else
    if (g < 0) $display("note: bad grant %0d", g);
`endif
  endtask

  // Reference winner: 1 = icache, 2 = dcache, 0 = none.
  function automatic int ref_pick(input logic icr, input logic dcr);
    if (icr && dcr) begin
`ifdef AEXM_MEMARB_RR_EN
      return (last_ref == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (dcr) return 2;
    if (icr) return 1;
    return 0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_valid"}, mem_cmd_valid_o, 0);
    chk({tag, "_addr"},      mem_addr_o, 0);
    chk({tag, "_we"},        mem_we_o, 0);
    chk({tag, "_wdata"},     mem_wdata_o, 0);
    chk({tag, "_ic_rdata"},  ic_rdata_o, 0);
    chk({tag, "_ic_rvalid"}, ic_rvalid_o, 0);
    chk({tag, "_ic_done"},   ic_done_o, 0);
    chk({tag, "_dc_rdata"},  dc_rdata_o, 0);
    chk({tag, "_dc_rvalid"}, dc_rvalid_o, 0);
    chk({tag, "_dc_done"},   dc_done_o, 0);
    chk({tag, "_dc_wnext"},  dc_wnext_o, 0);
  endtask

  // Runs one full grant starting in an IDLE cycle with requests already driven.
  task automatic do_burst(input int g, input logic we, input logic [31:0] a,
                          input int stall, input bit drop_mid);
    int          beats;
    int          cyc;
    logic        fire;
    logic [31:0] d;
    logic [31:0] w;
    #1;
    chk("idle_cmd_valid", mem_cmd_valid_o, 0);
    tick();
    for (int s = 0; s < stall; s++) begin
      mem_cmd_ready = 1'b0;
      mem_rvalid    = 1'($urandom_range(0, 1));
      mem_rdata     = $urandom;
      #1;
      chk("bp_cmd_valid", mem_cmd_valid_o, 1);
      chk("bp_addr", mem_addr_o, a);
      chk("bp_we", mem_we_o, we);
      chk("bp_ic_rvalid", ic_rvalid_o, 0);
      chk("bp_dc_rvalid", dc_rvalid_o, 0);
      tick();
    end
    mem_cmd_ready = 1'b1;
    mem_rvalid    = 1'b0;
    #1;
    chk("cmd_valid", mem_cmd_valid_o, 1);
    chk("cmd_addr", mem_addr_o, a);
    chk("cmd_we", mem_we_o, we);
    tick();
    mem_cmd_ready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < BEATS && cyc < 200) begin
      fire = (pat.size() > 0) ? pat.pop_front() : ($urandom_range(0, 2) != 0);
      d    = (dq.size() > 0) ? dq.pop_front() : $urandom;
      w    = $urandom;
      mem_rdata = d;
      dc_wdata  = w;
      if (we) begin
        mem_wready = fire;
        mem_rvalid = 1'($urandom_range(0, 1));
      end else begin
        mem_rvalid = fire;
        mem_wready = 1'($urandom_range(0, 1));
      end
      if (drop_mid && beats == 1) begin
        if (g == 1) ic_req = 1'b0;
        else dc_req = 1'b0;
      end
      #1;
      if (we) begin
        chk("wr_wnext", dc_wnext_o, fire);
        chk("wr_wdata", mem_wdata_o, w);
        chk("wr_ic_rvalid", ic_rvalid_o, 0);
        chk("wr_dc_rvalid", dc_rvalid_o, 0);
      end else begin
        chk("rd_ic_rvalid", ic_rvalid_o, (g == 1) && fire);
        chk("rd_dc_rvalid", dc_rvalid_o, (g == 2) && fire);
        if (fire) chk("rd_rdata", (g == 1) ? ic_rdata_o : dc_rdata_o, d);
        chk("rd_wnext", dc_wnext_o, 0);
      end
      chk("data_no_done", {ic_done_o, dc_done_o}, 0);
      if (fire) beats++;
      cyc++;
      tick();
    end
    chk("data_beats_in_budget", beats, BEATS);
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    #1;
    chk("done_ic", ic_done_o, g == 1);
    chk("done_dc", dc_done_o, g == 2);
    chk("done_cmd_valid", mem_cmd_valid_o, 0);
    if (g == 1) ic_req = 1'b0;
    else dc_req = 1'b0;
    set_last(g);
    tick();
    chk("post_done_pulse", {ic_done_o, dc_done_o}, 0);
  endtask

  task automatic serve(input int stall, input bit drop_mid);
    int          g;
    logic        we;
    logic [31:0] a;
    g  = ref_pick(ic_req, dc_req);
    we = (g == 2) ? dc_we : 1'b0;
    a  = (g == 2) ? dc_addr : ic_addr;
    a  = a - (a % LINE);
    do_burst(g, we, a, stall, drop_mid);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state with memory inputs active.
    rst_n = 1'b0;
    mem_rvalid = 1'b1;
    mem_wready = 1'b1;
    dc_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    tick();
    tick();
    chk_zero("reset");
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    rst_n = 1'b1;
    tick();

    // Stray beat in IDLE.
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    #1;
    chk("stray_ic_rvalid", ic_rvalid_o, 0);
    chk("stray_dc_rvalid", dc_rvalid_o, 0);
    tick();
    mem_rvalid = 1'b0;

    // Icache fill alone with beats A0..A3.
    ic_addr = 32'h0000_1234;
    ic_req = 1'b1;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    serve(1, 1'b0);

    // Dcache writeback with ready gaps 1,0,1,1,0,1.
    dc_addr = 32'h8000_0F3C;
    dc_we = 1'b1;
    dc_req = 1'b1;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    serve(0, 1'b0);

    // Command backpressure for 5 cycles on an icache fill.
    ic_addr = 32'h0001_00FF;
    ic_req = 1'b1;
    serve(5, 1'b0);

    // Tie, then a fresh dcache request against the still-pending icache.
    ic_addr = 32'h0000_2000;
    dc_addr = 32'h0000_3004;
    dc_we = 1'b0;
    ic_req = 1'b1;
    dc_req = 1'b1;
    serve(0, 1'b0);
    dc_req = 1'b1;
    dc_we = 1'b1;
    dc_addr = 32'h0000_4010;
    serve(0, 1'b0);
    while (ic_req || dc_req) serve(0, 1'b0);

    // Randomized request mixes, including requests dropped mid-grant.
    for (int it = 0; it < 12; it++) begin
      ic_addr = $urandom;
      dc_addr = $urandom;
      dc_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: ic_req = 1'b1;
        1: dc_req = 1'b1;
        default: begin
          ic_req = 1'b1;
          dc_req = 1'b1;
        end
      endcase
      while (ic_req || dc_req) serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset after two beats of an icache fill.
    ic_addr = 32'h0000_5550;
    ic_req = 1'b1;
    tick();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_wready = 1'b1;
    #1;
    chk_zero("rst_mid");
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    rst_n = 1'b1;
    set_last(1);
    serve(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aexm_memarb.md
Name: aexm_memarb

Overview:
- Arbitrates the instruction-cache and data-cache refill/writeback traffic onto the single external memory port of the aexm core.
- Sequences each grant as a command phase followed by a fixed-length burst of BEATS words, and routes the data beats to or from the granted cache.
- Sits between the aexm_edk32 cache pair and the system memory controller. Both caches hold their busy outputs high while a request is pending.

Parameters:
- BEATS, 4, words per burst; must be a power of two, 2..16.
- AW, 32, memory address width.
- BW, clog2(BEATS), beat counter width (derived; not to be overridden).

Ports:
- sys_clk_i  in  1  core clock; all state changes on the rising edge.
- sys_rst_i  in  1  synchronous, active-low reset.
- ic_req_i  in  1  icache line-fill request; held until ic_done_o.
- ic_addr_i  in  AW  icache line address; low log2(BEATS)+2 bits are ignored.
- ic_rdata_o  out  32  fill word.
- ic_rvalid_o  out  1  ic_rdata_o valid this cycle.
- ic_done_o  out  1  one-cycle pulse after the last fill beat.
- dc_req_i  in  1  dcache request; held until dc_done_o.
- dc_we_i  in  1  1 = writeback, 0 = fill; sampled at grant.
- dc_addr_i  in  AW  dcache line address.
- dc_wdata_i  in  32  writeback word for the current beat.
- dc_wnext_o  out  1  current writeback word consumed; the cache advances to the next word.
- dc_rdata_o  out  32  fill word.
- dc_rvalid_o  out  1  dc_rdata_o valid this cycle.
- dc_done_o  out  1  one-cycle pulse after the last beat.
- mem_cmd_valid_o  out  1  command valid.
- mem_cmd_ready_i  in  1  command accepted when valid and ready are both high.
- mem_we_o  out  1  command direction.
- mem_addr_o  out  AW  line-aligned address; low bits are forced to 0.
- mem_wdata_o  out  32  write beat data.
- mem_wready_i  in  1  write beat accepted this cycle.
- mem_rdata_i  in  32  read beat data.
- mem_rvalid_i  in  1  read beat valid.

Behaviour:
- Reset (sys_rst_i low at a clock edge):
  - state = IDLE, grant = none, beat counter = 0.
  - All valid, done and wnext outputs are 0.
  - mem_addr_o, mem_we_o and the data outputs are 0.
  - Reset during a burst abandons the burst immediately. The memory side is also under reset, so no recovery handshake is performed.
- States:
  - IDLE: if any request is high, select the winner, latch its address (line-aligned) and direction (we = dc_we_i for the dcache, 0 for the icache), then go to CMD. The winner is chosen the same cycle and the command is issued from the next cycle.
  - CMD: mem_cmd_valid_o = 1, holding the latched address and direction. On mem_cmd_ready_i, go to DATA with beat counter = 0. mem_cmd_valid_o must not drop before it is accepted.
  - DATA, read:
    - Each mem_rvalid_i cycle forwards mem_rdata_i combinationally to the granted cache's rdata, with rvalid = 1 in the same cycle, and increments the counter.
    - The non-granted cache's rvalid stays 0.
  - DATA, write:
    - mem_wdata_o = dc_wdata_i combinationally.
    - Each mem_wready_i cycle pulses dc_wnext_o and increments the counter.
  - On the beat where counter == BEATS-1 and the beat fires, go to DONE.
  - DONE: pulse the granted cache's done for exactly one cycle, record the last grant, clear grant, return to IDLE.
- Latency: a request can be re-granted no sooner than the cycle after DONE, so minimum request-to-command latency is 1 cycle, and back-to-back grants are separated by 2 idle cycles at most.
- Arbitration (default): fixed priority, dcache wins over icache. This avoids stalling memory ops, since cpu_mode_memop holds the pipeline.
- Boundary conditions:
  - A request dropped mid-grant is ignored; the burst completes.
  - Beats that arrive while in IDLE or CMD are dropped and never forwarded.
  - mem_rvalid_i during a write grant is ignored.
  - The counter wraps only through DONE and never overflows BEATS-1.

Optional Feature:
- Macro: AEXM_MEMARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, the cache not granted last wins. last_grant resets to icache, so the dcache wins the first tie.
- Undefined: fixed dcache priority, no last_grant register.

Decomposition:
- Package aexm_memarb_pkg holds:
  - state encoding IDLE=2'd0, CMD=2'd1, DATA=2'd2, DONE=2'd3;
  - grant encoding GNT_NONE, GNT_IC, GNT_DC;
  - the line-offset mask derived from BEATS.
- Sub-module aexm_memarb_pick is natural: the combinational winner selection, including the optional round-robin, taking ic_req, dc_req and last_grant and producing the grant.

Test Plan:
- Icache fill alone: ic_req_i=1, ic_addr_i=0x0000_1234 -> mem_addr_o=0x0000_1230, mem_we_o=0; four mem_rvalid_i beats 0xA0..0xA3 appear on ic_rdata_o with ic_rvalid_o; ic_done_o pulses once; dc_rvalid_o stays 0.
- Dcache writeback with gaps: dc_we_i=1, mem_wready_i pattern 1,0,1,1,0,1 -> exactly 4 dc_wnext_o pulses aligned to the ready cycles; dc_done_o the cycle after the 4th.
- Simultaneous requests in the same cycle -> dcache is granted first, icache second. With AEXM_MEMARB_RR_EN, after a dcache grant plus a new tie the icache is granted.
- Command backpressure: mem_cmd_ready_i low for 5 cycles -> mem_cmd_valid_o and mem_addr_o stay stable; no beats are forwarded.
- Stray beat: mem_rvalid_i pulsed in IDLE -> no rvalid on either cache.
- Reset mid-burst: sys_rst_i low after beat 2 -> next cycle all outputs are 0, state IDLE; a fresh request is served with a full 4 beats.
